// File: rtl/fsqrt_sched.sv
// ---------------------------------------------------------------------------
// fsqrt_sched
//
// Issue/return scheduler around a non-stallable pipelined square-root unit.
// Requests enter on a valid/ready port. The operand is driven onto sq_x in
// the accept cycle and zero otherwise. Each tag travels down a shift register
// matched to the unit's latency, so it meets its own result on sq_y. The
// {tag, result} pair is then captured into a small first-word-fall-through
// FIFO. Admission is credit based: an operation is only accepted while fewer
// than DEPTH are in flight or queued, so every result arriving from the pipe
// always has a FIFO slot, even under output backpressure.
//
// Ports
//   clk        in   clock, rising edge
//   rstn       in   asynchronous active-low reset
//   in_valid   in   request present
//   in_ready   out  request can be accepted (from registered state only)
//   in_tag     in   request tag
//   in_x       in   IEEE-754 single operand
//   sq_x       out  operand to the square-root unit (zero when idle)
//   sq_y       in   result from the square-root unit, LAT cycles later
//   out_valid  out  head result available
//   out_ready  in   consumer takes the head result
//   out_tag    out  tag of the head result
//   out_y      out  head result, bit-exact copy of sq_y
// ---------------------------------------------------------------------------
module fsqrt_sched #(
    parameter int LAT   = 2,
    parameter int DEPTH = 4,
    parameter int TAGW  = 4
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [TAGW-1:0] in_tag,
    input  logic [31:0]     in_x,
    output logic [31:0]     sq_x,
    input  logic [31:0]     sq_y,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [TAGW-1:0] out_tag,
    output logic [31:0]     out_y
);

    // Pointer and counter widths. Counters need one extra bit to hold DEPTH.
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1'b1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(1'b0);
    localparam logic [PW-1:0] PTR_ONE = PW'(1'b1);
    localparam logic [PW-1:0] PTR_ZERO = PW'(1'b0);

    // Handshake events for this cycle.
    logic accept_s;
    logic pop_s;
    logic push_s;

    // Credit counter: operations in the pipe plus operations in the FIFO.
    logic [CW-1:0] outstanding_q;
    logic [CW-1:0] outstanding_d;

    // Tag pipe, stage LAT-1 is aligned with sq_y.
    logic [LAT-1:0]  pipe_v_q;
    logic [LAT-1:0]  pipe_v_d;
    logic [TAGW-1:0] pipe_tag_q [LAT];
    logic [TAGW-1:0] pipe_tag_d [LAT];

    // Result FIFO storage and bookkeeping.
    logic [TAGW-1:0] mem_tag_q [DEPTH];
    logic [TAGW-1:0] mem_tag_d [DEPTH];
    logic [31:0]     mem_y_q [DEPTH];
    logic [31:0]     mem_y_d [DEPTH];
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q;
    logic [PW-1:0]   rd_ptr_d;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_d;

    // Port-facing combinational outputs; in_ready and out_* depend on flops only.
    always_comb begin
        in_ready  = (outstanding_q < DEPTH_C);
        out_valid = (count_q != CNT_ZERO);
        out_tag   = mem_tag_q[rd_ptr_q];
        out_y     = mem_y_q[rd_ptr_q];
        accept_s  = in_valid && in_ready;
        pop_s     = out_valid && out_ready;
        push_s    = pipe_v_q[LAT-1];
        // Idle cycles feed zero so the unit never sees stale operands.
        if (accept_s) begin
            sq_x = in_x;
        end else begin
            sq_x = 32'h0000_0000;
        end
    end

    // Credit counter next state: accept and pop in one cycle cancel out.
    always_comb begin
        outstanding_d = outstanding_q;
        if (accept_s && !pop_s) begin
            outstanding_d = outstanding_q + CNT_ONE;
        end else if (!accept_s && pop_s) begin
            outstanding_d = outstanding_q - CNT_ONE;
        end else begin
            outstanding_d = outstanding_q;
        end
    end

    // Tag pipe next state: stage 0 samples the accept, later stages shift.
    always_comb begin
        pipe_v_d      = pipe_v_q;
        pipe_tag_d    = pipe_tag_q;
        pipe_v_d[0]   = accept_s;
        pipe_tag_d[0] = in_tag;
        for (int i = 1; i < LAT; i++) begin
            pipe_v_d[i]   = pipe_v_q[i-1];
            pipe_tag_d[i] = pipe_tag_q[i-1];
        end
    end

    // FIFO write side: capture {tag, sq_y} when the aligned tag stage is valid.
    always_comb begin
        mem_tag_d = mem_tag_q;
        mem_y_d   = mem_y_q;
        wr_ptr_d  = wr_ptr_q;
        if (push_s) begin
            mem_tag_d[wr_ptr_q] = pipe_tag_q[LAT-1];
            mem_y_d[wr_ptr_q]   = sq_y;
            wr_ptr_d            = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
    end

    // FIFO read side and occupancy; pointers wrap naturally (DEPTH is 2^n).
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (push_s && !pop_s) begin
            count_d = count_q + CNT_ONE;
        end else if (!push_s && pop_s) begin
            count_d = count_q - CNT_ONE;
        end else begin
            count_d = count_q;
        end
    end

    // Credit counter and tag pipe registers; reset drops every in-flight op.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            outstanding_q <= CNT_ZERO;
            pipe_v_q      <= {LAT{1'b0}};
            for (int i = 0; i < LAT; i++) begin
                pipe_tag_q[i] <= {TAGW{1'b0}};
            end
        end else begin
            outstanding_q <= outstanding_d;
            pipe_v_q      <= pipe_v_d;
            pipe_tag_q    <= pipe_tag_d;
        end
    end

    // FIFO registers; storage is cleared so the head reads zero after reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= PTR_ZERO;
            rd_ptr_q <= PTR_ZERO;
            count_q  <= CNT_ZERO;
            for (int i = 0; i < DEPTH; i++) begin
                mem_tag_q[i] <= {TAGW{1'b0}};
                mem_y_q[i]   <= 32'h0000_0000;
            end
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            mem_tag_q <= mem_tag_d;
            mem_y_q   <= mem_y_d;
        end
    end

endmodule
